// File: rtl/mpuc_pkg.sv
// rtl/mpuc_pkg.sv - coefficient constants, coefficient codes and twiddle decode for the W16 rotator
package mpuc_pkg;

  localparam int C383 = 25080;
  localparam int C707 = 46341;
  localparam int C924 = 60547;

  typedef enum logic [2:0] {
    COEF_ZERO,
    COEF_C383,
    COEF_C707,
    COEF_C924,
    COEF_ONE
  } coef_e;

  typedef struct packed {
    coef_e cos_code;
    coef_e sin_code;
    logic  cos_neg;
    logic  sin_neg;
  } twiddle_t;

  // Magnitudes repeat every quadrant; odd quadrants swap the cos and sin tables.
  function automatic twiddle_t twiddle_decode(input logic [3:0] k);
    twiddle_t t;
    coef_e    even_mag;
    coef_e    odd_mag;
    case (k[1:0])
      2'd0:    begin even_mag = COEF_ONE;  odd_mag = COEF_ZERO; end
      2'd1:    begin even_mag = COEF_C924; odd_mag = COEF_C383; end
      2'd2:    begin even_mag = COEF_C707; odd_mag = COEF_C707; end
      default: begin even_mag = COEF_C383; odd_mag = COEF_C924; end
    endcase
    t.cos_code = k[2] ? odd_mag : even_mag;
    t.sin_code = k[2] ? even_mag : odd_mag;
    t.cos_neg  = (k > 4'd4) && (k < 4'd12);
    t.sin_neg  = (k > 4'd8);
    return t;
  endfunction

endpackage

// File: rtl/mpuc_cmul_const.sv
// rtl/mpuc_cmul_const.sv - signed sample times unsigned Q0.CW coefficient code, rounded half up to W+1 bits
module mpuc_cmul_const
  import mpuc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic signed [W-1:0] x,
  input  coef_e               code,
  output logic signed [W:0]   p
);

  localparam int PW = W + CW + 1;
  localparam logic [CW-1:0] K383 = CW'(C383 >> (16 - CW));
  localparam logic [CW-1:0] K707 = CW'(C707 >> (16 - CW));
  localparam logic [CW-1:0] K924 = CW'(C924 >> (16 - CW));
  localparam logic signed [PW-1:0] HALF = PW'(1) << (CW - 1);

  logic [CW-1:0]        coef;
  logic signed [PW-1:0] xe;
  logic signed [PW-1:0] ce;
  logic signed [PW-1:0] prod;

  always_comb begin
    coef = '0;
    case (code)
      COEF_C383: coef = K383;
      COEF_C707: coef = K707;
      COEF_C924: coef = K924;
      default:   coef = '0;
    endcase
  end

  assign xe   = PW'(x);
  assign ce   = PW'(coef);
  assign prod = xe * ce;

  // Arithmetic shift after adding half gives floor(x*C/2^CW + 1/2) for both signs.
  always_comb begin
    p = '0;
    case (code)
      COEF_ONE:  p = {x[W-1], x};
      COEF_ZERO: p = '0;
      default:   p = (W+1)'((prod + HALF) >>> CW);
    endcase
  end

endmodule

// File: rtl/mpuc_rot16.sv
// rtl/mpuc_rot16.sv - 3-stage W16^k complex rotator with index accumulator; MPUC_ROT_SAT_EN selects saturation over wrap
module mpuc_rot16
  import mpuc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                ED,
  input  logic                DS,
  input  logic                START,
  input  logic [3:0]          STEP,
  input  logic signed [W-1:0] DR,
  input  logic signed [W-1:0] DI,
  output logic signed [W-1:0] DOR,
  output logic signed [W-1:0] DOI,
  output logic                RDY,
  output logic [3:0]          KOUT
);

  logic [3:0] acc;
  logic [3:0] k_in;
  twiddle_t   tw_in;

  logic                v1;
  logic signed [W-1:0] dr1, di1;
  twiddle_t            tw1;
  logic [3:0]          k1;

  logic signed [W:0]   prc, pis, pic, prs;
  logic                v2;
  logic signed [W:0]   prc2, pis2, pic2, prs2;
  logic                cneg2, sneg2;
  logic [3:0]          k2;

  logic signed [W+1:0] sum_r, sum_i;

  function automatic logic signed [W+1:0] apply_sign(input logic signed [W:0] p, input logic neg);
    logic signed [W+1:0] e;
    e = (W+2)'(p);
    return neg ? -e : e;
  endfunction

`ifdef MPUC_ROT_SAT_EN
  localparam logic signed [W+1:0] SMAX = (W+2)'(2**(W-1) - 1);
  localparam logic signed [W+1:0] SMIN = -SMAX - 1;

  function automatic logic signed [W-1:0] reduce(input logic signed [W+1:0] s);
    if (s > SMAX) return W'(SMAX);
    if (s < SMIN) return W'(SMIN);
    return W'(s);
  endfunction
`else
  function automatic logic signed [W-1:0] reduce(input logic signed [W+1:0] s);
    return W'(s);
  endfunction
`endif

  assign k_in  = START ? 4'd0 : acc;
  assign tw_in = twiddle_decode(k_in);

  // S1: index accumulator, input capture and twiddle decode
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc <= '0;
      v1  <= 1'b0;
      dr1 <= '0;
      di1 <= '0;
      tw1 <= '{cos_code: COEF_ZERO, sin_code: COEF_ZERO, cos_neg: 1'b0, sin_neg: 1'b0};
      k1  <= '0;
    end else if (ED) begin
      v1 <= DS;
      if (DS) begin
        acc <= k_in + STEP;
        dr1 <= DR;
        di1 <= DI;
        tw1 <= tw_in;
        k1  <= k_in;
      end
    end
  end

  mpuc_cmul_const #(.W(W), .CW(CW)) u_rc (.x(dr1), .code(tw1.cos_code), .p(prc));
  mpuc_cmul_const #(.W(W), .CW(CW)) u_is (.x(di1), .code(tw1.sin_code), .p(pis));
  mpuc_cmul_const #(.W(W), .CW(CW)) u_ic (.x(di1), .code(tw1.cos_code), .p(pic));
  mpuc_cmul_const #(.W(W), .CW(CW)) u_rs (.x(dr1), .code(tw1.sin_code), .p(prs));

  // S2: magnitude products; signs travel alongside and are applied in S3
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v2    <= 1'b0;
      prc2  <= '0;
      pis2  <= '0;
      pic2  <= '0;
      prs2  <= '0;
      cneg2 <= 1'b0;
      sneg2 <= 1'b0;
      k2    <= '0;
    end else if (ED) begin
      v2 <= v1;
      if (v1) begin
        prc2  <= prc;
        pis2  <= pis;
        pic2  <= pic;
        prs2  <= prs;
        cneg2 <= tw1.cos_neg;
        sneg2 <= tw1.sin_neg;
        k2    <= k1;
      end
    end
  end

  assign sum_r = apply_sign(prc2, cneg2) + apply_sign(pis2, sneg2);
  assign sum_i = apply_sign(pic2, cneg2) - apply_sign(prs2, sneg2);

  // S3: combine, reduce to W bits; data outputs hold between valid samples
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DOR  <= '0;
      DOI  <= '0;
      RDY  <= 1'b0;
      KOUT <= '0;
    end else if (ED) begin
      RDY <= v2;
      if (v2) begin
        DOR  <= reduce(sum_r);
        DOI  <= reduce(sum_i);
        KOUT <= k2;
      end
    end
  end

endmodule

// File: tb/tb_mpuc_rot16.sv
// tb/tb_mpuc_rot16.sv - directed self-checking bench for mpuc_rot16 (W=16, CW=16)
module tb_mpuc_rot16;

  logic               CLK;
  logic               RSTN;
  logic               ED;
  logic               DS;
  logic               START;
  logic [3:0]         STEP;
  logic signed [15:0] DR;
  logic signed [15:0] DI;
  logic signed [15:0] DOR;
  logic signed [15:0] DOI;
  logic               RDY;
  logic [3:0]         KOUT;

  int errors = 0;
  int checks = 0;

`ifdef MPUC_ROT_SAT_EN
  localparam logic signed [15:0] E_BIG_K2  = 16'sd32767;
  localparam logic signed [15:0] E_NEG_MIN = 16'sd32767;
`else
  localparam logic signed [15:0] E_BIG_K2  = -16'sd19196;
  localparam logic signed [15:0] E_NEG_MIN = 16'sh8000;
`endif

  mpuc_rot16 #(.W(16), .CW(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .ED(ED), .DS(DS), .START(START), .STEP(STEP),
    .DR(DR), .DI(DI), .DOR(DOR), .DOI(DOI), .RDY(RDY), .KOUT(KOUT)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic ed, input logic ds, input logic st, input logic [3:0] sp,
                       input logic signed [15:0] xr, input logic signed [15:0] xi);
    ED = ed; DS = ds; START = st; STEP = sp; DR = xr; DI = xi;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #2 RSTN = 1'b0;
    @(negedge CLK);
    checks++; if (RDY !== 1'b0)  begin errors++; $display("FAIL reset_rdy got=%b exp=0", RDY); end
    checks++; if (DOR !== 16'sd0) begin errors++; $display("FAIL reset_dor got=%0d exp=0", DOR); end
    checks++; if (DOI !== 16'sd0) begin errors++; $display("FAIL reset_doi got=%0d exp=0", DOI); end
    checks++; if (KOUT !== 4'd0)  begin errors++; $display("FAIL reset_kout got=%0d exp=0", KOUT); end
    RSTN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_step1();
    logic signed [15:0] er [4];
    logic signed [15:0] ei [4];
    logic [3:0]         ek [4];
    er = '{16'sd1000, 16'sd924, 16'sd707, 16'sd383};
    ei = '{16'sd0, -16'sd383, -16'sd707, -16'sd924};
    ek = '{4'd0, 4'd1, 4'd2, 4'd3};
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 1'b1, c == 0, 4'd1, 16'sd1000, 16'sd0);
      else       drive(1'b1, 1'b0, 1'b0, 4'd0, 16'sd0, 16'sd0);
      checks++;
      if (c >= 2 && c < 6) begin
        if (RDY !== 1'b1 || DOR !== er[c-2] || DOI !== ei[c-2] || KOUT !== ek[c-2]) begin
          errors++;
          $display("FAIL step1[%0d] got rdy=%b dor=%0d doi=%0d k=%0d exp rdy=1 dor=%0d doi=%0d k=%0d",
                   c-2, RDY, DOR, DOI, KOUT, er[c-2], ei[c-2], ek[c-2]);
        end
      end else if (RDY !== 1'b0) begin
        errors++; $display("FAIL step1_idle[%0d] got rdy=%b exp=0", c, RDY);
      end
    end
  endtask

  task automatic test_negative_round();
    logic signed [15:0] er [2];
    logic signed [15:0] ei [2];
    logic [3:0]         ek [2];
    er = '{-16'sd1000, -16'sd707};
    ei = '{16'sd0, 16'sd707};
    ek = '{4'd0, 4'd2};
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(1'b1, 1'b1, c == 0, 4'd2, -16'sd1000, 16'sd0);
      else       drive(1'b1, 1'b0, 1'b0, 4'd0, 16'sd0, 16'sd0);
      checks++;
      if (c >= 2 && c < 4) begin
        if (RDY !== 1'b1 || DOR !== er[c-2] || DOI !== ei[c-2] || KOUT !== ek[c-2]) begin
          errors++;
          $display("FAIL neg_round[%0d] got rdy=%b dor=%0d doi=%0d k=%0d exp rdy=1 dor=%0d doi=%0d k=%0d",
                   c-2, RDY, DOR, DOI, KOUT, er[c-2], ei[c-2], ek[c-2]);
        end
      end else if (RDY !== 1'b0) begin
        errors++; $display("FAIL neg_round_idle[%0d] got rdy=%b exp=0", c, RDY);
      end
    end
  endtask

  task automatic test_quadrants();
    logic signed [15:0] er [4];
    logic signed [15:0] ei [4];
    logic [3:0]         ek [4];
    er = '{16'sd300, -16'sd200, -16'sd300, 16'sd200};
    ei = '{-16'sd200, -16'sd300, 16'sd200, 16'sd300};
    ek = '{4'd0, 4'd4, 4'd8, 4'd12};
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 1'b1, c == 0, 4'd4, 16'sd300, -16'sd200);
      else       drive(1'b1, 1'b0, 1'b0, 4'd0, 16'sd0, 16'sd0);
      checks++;
      if (c >= 2 && c < 6) begin
        if (RDY !== 1'b1 || DOR !== er[c-2] || DOI !== ei[c-2] || KOUT !== ek[c-2]) begin
          errors++;
          $display("FAIL quadrant[%0d] got rdy=%b dor=%0d doi=%0d k=%0d exp rdy=1 dor=%0d doi=%0d k=%0d",
                   c-2, RDY, DOR, DOI, KOUT, er[c-2], ei[c-2], ek[c-2]);
        end
      end else if (RDY !== 1'b0) begin
        errors++; $display("FAIL quadrant_idle[%0d] got rdy=%b exp=0", c, RDY);
      end
    end
  endtask

  task automatic test_overflow();
    logic               st [4];
    logic [3:0]         sp [4];
    logic signed [15:0] xr [4];
    logic signed [15:0] xi [4];
    logic signed [15:0] er [4];
    logic signed [15:0] ei [4];
    logic [3:0]         ek [4];
    st = '{1'b1, 1'b0, 1'b1, 1'b0};
    sp = '{4'd2, 4'd2, 4'd8, 4'd8};
    xr = '{16'sd32767, 16'sd32767, 16'sh8000, 16'sh8000};
    xi = '{16'sd32767, 16'sd32767, 16'sd0, 16'sd0};
    er = '{16'sd32767, E_BIG_K2, 16'sh8000, E_NEG_MIN};
    ei = '{16'sd32767, 16'sd0, 16'sd0, 16'sd0};
    ek = '{4'd0, 4'd2, 4'd0, 4'd8};
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 1'b1, st[c], sp[c], xr[c], xi[c]);
      else       drive(1'b1, 1'b0, 1'b0, 4'd0, 16'sd0, 16'sd0);
      checks++;
      if (c >= 2 && c < 6) begin
        if (RDY !== 1'b1 || DOR !== er[c-2] || DOI !== ei[c-2] || KOUT !== ek[c-2]) begin
          errors++;
          $display("FAIL overflow[%0d] got rdy=%b dor=%0d doi=%0d k=%0d exp rdy=1 dor=%0d doi=%0d k=%0d",
                   c-2, RDY, DOR, DOI, KOUT, er[c-2], ei[c-2], ek[c-2]);
        end
      end else if (RDY !== 1'b0) begin
        errors++; $display("FAIL overflow_idle[%0d] got rdy=%b exp=0", c, RDY);
      end
    end
  endtask

  task automatic test_ed_freeze();
    logic ed [12];
    logic ds [12];
    logic st [12];
    logic rdy_exp [12];
    int   oidx [12];
    logic signed [15:0] er [5];
    logic signed [15:0] ei [5];
    logic [3:0]         ek [5];
    ed      = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    ds      = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    st      = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    rdy_exp = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    oidx    = '{-1, -1, 0, 0, 0, 1, 2, 3, 3, 3, 4, 4};
    er = '{16'sd1000, 16'sd383, -16'sd707, -16'sd924, 16'sd1000};
    ei = '{16'sd0, -16'sd924, -16'sd707, 16'sd383, 16'sd0};
    ek = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd0};
    for (int c = 0; c < 12; c++) begin
      if (ed[c]) drive(1'b1, ds[c], st[c], 4'd3, 16'sd1000, 16'sd0);
      else       drive(1'b0, ds[c], st[c], 4'd3, 16'sd5, 16'sd7);
      checks++;
      if (RDY !== rdy_exp[c]) begin
        errors++; $display("FAIL freeze_rdy[%0d] got=%b exp=%b", c, RDY, rdy_exp[c]);
      end
      if (oidx[c] >= 0) begin
        checks++;
        if (DOR !== er[oidx[c]] || DOI !== ei[oidx[c]] || KOUT !== ek[oidx[c]]) begin
          errors++;
          $display("FAIL freeze_data[%0d] got dor=%0d doi=%0d k=%0d exp dor=%0d doi=%0d k=%0d",
                   c, DOR, DOI, KOUT, er[oidx[c]], ei[oidx[c]], ek[oidx[c]]);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic signed [15:0] er [2];
    logic signed [15:0] ei [2];
    logic [3:0]         ek [2];
    er = '{16'sd1000, -16'sd383};
    ei = '{16'sd0, -16'sd924};
    ek = '{4'd0, 4'd5};
    drive(1'b1, 1'b1, 1'b1, 4'd5, 16'sd1234, 16'sd0);
    drive(1'b1, 1'b1, 1'b0, 4'd5, 16'sd1234, 16'sd0);
    DS = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if (RDY !== 1'b0 || DOR !== 16'sd0 || DOI !== 16'sd0 || KOUT !== 4'd0) begin
      errors++;
      $display("FAIL midreset got rdy=%b dor=%0d doi=%0d k=%0d exp 0 0 0 0", RDY, DOR, DOI, KOUT);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(1'b1, 1'b1, 1'b0, 4'd5, 16'sd1000, 16'sd0);
      else       drive(1'b1, 1'b0, 1'b0, 4'd0, 16'sd0, 16'sd0);
      checks++;
      if (c >= 2 && c < 4) begin
        if (RDY !== 1'b1 || DOR !== er[c-2] || DOI !== ei[c-2] || KOUT !== ek[c-2]) begin
          errors++;
          $display("FAIL post_reset[%0d] got rdy=%b dor=%0d doi=%0d k=%0d exp rdy=1 dor=%0d doi=%0d k=%0d",
                   c-2, RDY, DOR, DOI, KOUT, er[c-2], ei[c-2], ek[c-2]);
        end
      end else if (RDY !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle[%0d] got rdy=%b exp=0", c, RDY);
      end
    end
  endtask

  initial begin
    CLK = 1'b0; RSTN = 1'b1; ED = 1'b1; DS = 1'b0; START = 1'b0;
    STEP = 4'd0; DR = 16'sd0; DI = 16'sd0;
    test_reset();
    test_step1();
    test_negative_round();
    test_quadrants();
    test_overflow();
    test_ed_freeze();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpuc_rot16.md
# mpuc_rot16

Parametrised constant-coefficient complex rotator for the FFT datapath; multiplies each complex sample by the 16-point twiddle W16^k = exp(-j·2πk/16).
- Generalises the fixed 0.924/0.383 multiplier with ‑j option to all 16 twiddles, a parametric width, and parallel real/imag inputs.
- Adds an internal twiddle-index accumulator that sequences k = 0, s, 2s, … across an FFT column.
- Sits between a butterfly stage and the next reorder buffer.

## Interface
- W, 16: sample width, signed two's complement (DR, DI, DOR, DOI).
- CW, 16: coefficient fraction bits; coefficients are unsigned Q0.CW.
- CLK  in  1  rising-edge clock.
- RSTN  in  1  asynchronous active-low reset.
- ED  in  1  global enable; when low every register, including the accumulator, holds.
- DS  in  1  input sample valid; sampled only when ED=1.
- START  in  1  with DS=1: this sample is the first of a column; its index is forced to 0.
- STEP  in  4  index increment per valid sample, mod 16.
- DR, DI  in  W  input real and imaginary parts.
- DOR, DOI  out  W  rotated output.
- RDY  out  1  output valid.
- KOUT  out  4  twiddle index applied to the current output (debug and verification).

## Operation
- Index accumulator `acc[3:0]` (per valid sample, i.e. ED=1 and DS=1):
  - START=1: k=0, `acc<=STEP`.
  - Otherwise: k=acc, `acc<=acc+STEP` (mod 16).
  - START with DS=0 is ignored.
- Rotation, with θ=πk/8:
  - DOR = DR·cosθ + DI·sinθ.
  - DOI = DI·cosθ − DR·sinθ.
- |cos| and |sin| are taken from {0, C383, C707, C924, 1.0}:
  - C383=25080, C707=46341, C924=60547 (Q0.16 values, rescaled by `>> (16-CW)` when CW<16).
  - Signs come from the octant decode of k.
  - k=0: output equals input exactly. k=4: DOR=DI, DOI=−DR. k=8: both parts negated. k=12: DOR=−DI, DOI=DR.
- Product rule: each partial product is computed as floor((x·C + 2^(CW-1)) / 2^CW), i.e. round half up (toward +inf).
  - A coefficient of 1.0 passes x unchanged; 0 gives 0.
- Products are W+1 bits. The sum or difference is formed in W+2 bits, then reduced to W bits per the Configuration section.
- Negating −2^(W-1) follows the same rule: saturates to 2^(W-1)−1 with saturation enabled, wraps without it.

## Timing
- Latency is 3 ED-enabled cycles from DS to RDY:
  - S1: register the inputs and decode k into coefficient codes and signs.
  - S2: register the four products.
  - S3: add or subtract, reduce to W bits, register DOR, DOI, RDY and KOUT.
- ED=0 freezes all stages. Outputs hold, and RDY keeps its value.
- RDY is high for exactly one enabled cycle per valid input. Back-to-back DS gives back-to-back RDY.
- DOR and DOI hold their last value when RDY=0.
- Reset: DOR=0, DOI=0, RDY=0, KOUT=0, acc=0, and all pipeline valids cleared. Reset mid-stream discards in-flight samples.
- First sample after reset with START=0 uses k=0, because acc=0.

## Configuration
- MPUC_ROT_SAT_EN defined: the W+2-bit result saturates to [−2^(W-1), 2^(W-1)−1].
- MPUC_ROT_SAT_EN undefined: the W low bits are kept (wrap).
- Both variants have identical latency.

## Structure
- Package `mpuc_pkg`:
  - Coefficient constants C383, C707, C924.
  - Coefficient-code enum {ZERO, C383, C707, C924, ONE}.
  - Function `twiddle_decode(k)`, returning the cos and sin codes plus sign bits.
- Sub-module `mpuc_cmul_const`: one signed input and a coefficient code in, rounded W+1-bit product out, combinational. Instantiated four times, feeding S2 registers.

## Test plan
- W=16, DR=1000, DI=0, START=1, STEP=1, four consecutive samples:
  - k=0 → (1000, 0).
  - k=1 → (924, −383).
  - k=2 → (707, −707).
  - k=3 → (383, −924).
  - RDY is high 3 cycles after each DS.
- DR=−1000, DI=0, k=2 → (−707, 707). Checks that negative rounding is floor, not truncation.
- DR=300, DI=−200, k=4 → (−200, −300); k=8 → (−300, 200); k=12 → (200, 300).
- DR=DI=32767, k=2:
  - DOR: with MPUC_ROT_SAT_EN it is 32767; without it, −19196.
  - DOI: 0 in both cases.
- Toggle ED low for 2 cycles mid-stream: outputs, RDY and acc freeze, and the sequence resumes with no loss or duplication. A START in a later column restarts the index at 0.
- Assert RSTN low with 2 samples in flight: RDY, DOR and DOI are 0 immediately. After release, a sample with START=0 uses k=0.
